// File: rtl/udar_pkg.sv
// Shared types and default sizing for the echo-width post-processing blocks.
package udar_pkg;

    localparam int UDAR_IN_LEN    = 8;
    localparam int UDAR_LOG_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        ACCUM   = 2'd2,
        PUBLISH = 2'd3
    } echo_filt_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle pulse on its
// rising edge. All flops reset to 0, so a level already high at reset release
// produces one pulse.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_out
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise_out = sync2_q & ~prev_q;

endmodule

// File: rtl/echo_avg_filter.sv
// Moving average over the last 2**LOG_DEPTH accepted echo widths, published over valid/ready.
// Define UDAR_RANGE_CHECK_EN to discard samples outside [MIN_CNT, MAX_CNT].
module echo_avg_filter
    import udar_pkg::*;
#(
    parameter int IN_LEN    = UDAR_IN_LEN,
    parameter int LOG_DEPTH = UDAR_LOG_DEPTH,
    parameter int MIN_CNT   = 1,
    parameter int MAX_CNT   = 250
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_LEN-1:0] cnt_in,
    input  logic              done_in,
    output logic [IN_LEN-1:0] avg_out,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              overrun
);

    localparam int DEPTH  = 1 << LOG_DEPTH;
    localparam int SUM_W  = IN_LEN + LOG_DEPTH;
    localparam int FILL_W = LOG_DEPTH + 1;
    localparam logic [IN_LEN-1:0] MIN_V = IN_LEN'(MIN_CNT);
    localparam logic [IN_LEN-1:0] MAX_V = IN_LEN'(MAX_CNT);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(DEPTH);

`ifdef UDAR_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic done_rise;
    logic reject;

    echo_filt_state_t  state_q, state_d;
    logic [IN_LEN-1:0]    sample_q, sample_d;
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic [IN_LEN-1:0]    ring_q [DEPTH];
    logic [IN_LEN-1:0]    ring_d [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [IN_LEN-1:0]    avg_out_q, avg_out_d;
    logic                 avg_valid_q, avg_valid_d;
    logic                 overrun_q, overrun_d;

    sync_edge u_done_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (done_in),
        .rise_out (done_rise)
    );

    assign reject = RANGE_EN && ((sample_q < MIN_V) || (sample_q > MAX_V));

    // Handshake: avg_out is transferred on any cycle with avg_valid && avg_ready;
    // avg_valid then drops unless PUBLISH loads a fresh result in that same cycle.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        sum_d       = sum_q;
        ring_d      = ring_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        avg_out_d   = avg_out_q;
        avg_valid_d = avg_valid_q;
        overrun_d   = 1'b0;

        if (avg_valid_q && avg_ready) begin
            avg_valid_d = 1'b0;
        end
        if (done_rise && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (done_rise) begin
                    sample_d = cnt_in;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                state_d = reject ? IDLE : ACCUM;
            end
            ACCUM: begin
                // Empty slots hold 0 during warm-up, so the subtraction is always exact.
                sum_d            = sum_q + SUM_W'(sample_q) - SUM_W'(ring_q[wr_ptr_q]);
                ring_d[wr_ptr_q] = sample_q;
                wr_ptr_d         = wr_ptr_q + LOG_DEPTH'(1);
                if (fill_q != FULL) begin
                    fill_d = fill_q + FILL_W'(1);
                end
                state_d = PUBLISH;
            end
            PUBLISH: begin
                if (fill_q == FULL) begin
                    avg_out_d   = sum_q[SUM_W-1:LOG_DEPTH];
                    avg_valid_d = 1'b1;
                    if (avg_valid_q && !avg_ready) begin
                        overrun_d = 1'b1;
                    end
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sample_q    <= '0;
            sum_q       <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            avg_out_q   <= '0;
            avg_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            sum_q       <= sum_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            avg_out_q   <= avg_out_d;
            avg_valid_q <= avg_valid_d;
            overrun_q   <= overrun_d;
            ring_q      <= ring_d;
        end
    end

    assign avg_out   = avg_out_q;
    assign avg_valid = avg_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_avg_filter.sv
// Directed bench for echo_avg_filter: expected averages are queued by the stimulus
// and popped by an independent monitor on every accepted output.
module tb_echo_avg_filter;
    import udar_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cnt_in;
    logic       done_in;
    logic [7:0] avg_out;
    logic       avg_valid;
    logic       avg_ready;
    logic       overrun;

    int n_checks   = 0;
    int n_fail     = 0;
    int ovr_cnt    = 0;
    int valid_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    echo_avg_filter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_in    (cnt_in),
        .done_in   (done_in),
        .avg_out   (avg_out),
        .avg_valid (avg_valid),
        .avg_ready (avg_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, inputs change just after the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun) ovr_cnt++;
            if (avg_valid) valid_seen++;
            if (avg_valid && avg_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0d expected none", avg_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("avg_out_transfer", avg_out, exp_v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [7:0] v);
        cnt_in  = v;
        done_in = 1'b1;
        repeat (8) tick();
        done_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vs;
        bit found;
        rst_n     = 1'b0;
        cnt_in    = '0;
        done_in   = 1'b0;
        avg_ready = 1'b1;
        repeat (3) tick();
        check("reset_avg_out", avg_out, 0);
        check("reset_avg_valid", avg_valid, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        tick();

        // Warm-up: nothing until the fourth sample.
        send_sample(8'd10);
        send_sample(8'd20);
        send_sample(8'd30);
        repeat (4) tick();
        check("warmup_no_valid", valid_seen, 0);
        exp_q.push_back(8'd25);
        send_sample(8'd40);
        drain("warmup_first_avg");

        // Sliding window and pointer wrap.
        exp_q.push_back(8'd35);
        send_sample(8'd50);
        drain("slide_50");
        exp_q.push_back(8'd45);
        send_sample(8'd60);
        drain("slide_60");
        check("no_overrun_streaming", ovr_cnt, 0);

        // Backpressure across two results.
        avg_ready = 1'b0;
        send_sample(8'd70);
        check("bp_valid_held", avg_valid, 1);
        check("bp_first_avg", avg_out, 55);
        send_sample(8'd80);
        check("bp_overrun_once", ovr_cnt, 1);
        check("bp_newer_avg", avg_out, 65);
        check("bp_valid_still", avg_valid, 1);
        exp_q.push_back(8'd65);
        avg_ready = 1'b1;
        drain("bp_release");
        tick();
        tick();
        check("bp_valid_dropped", avg_valid, 0);

        // Second rising edge while the FSM is still busy.
        exp_q.push_back(8'd75);
        cnt_in  = 8'd90;
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        tick();
        done_in = 1'b1;
        repeat (8) tick();
        done_in = 1'b0;
        repeat (4) tick();
        drain("busy_single_accum");
        check("busy_overrun", ovr_cnt, 2);
        exp_q.push_back(8'd85);
        send_sample(8'd100);
        drain("busy_followup");

        // Out-of-range counts.
`ifndef UDAR_RANGE_CHECK_EN
        exp_q.push_back(8'd67);
`endif
        send_sample(8'd0);
        drain("edge_zero");
`ifndef UDAR_RANGE_CHECK_EN
        exp_q.push_back(8'd111);
`endif
        send_sample(8'd255);
        drain("edge_ones");
`ifdef UDAR_RANGE_CHECK_EN
        exp_q.push_back(8'd95);
`else
        exp_q.push_back(8'd116);
`endif
        send_sample(8'd110);
        drain("edge_after");
        check("edge_no_overrun", ovr_cnt, 2);

        // Reset asserted while in PUBLISH with a result pending.
        avg_ready = 1'b0;
        send_sample(8'd120);
        cnt_in  = 8'd130;
        done_in = 1'b1;
        found   = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            if (dut.state_q == PUBLISH) found = 1'b1;
        end
        check("reach_publish", found, 1);
        check("pre_reset_valid", avg_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_avg_out", avg_out, 0);
        check("midreset_avg_valid", avg_valid, 0);
        check("midreset_overrun", overrun, 0);
        done_in = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_reset_idle", int'(dut.state_q), int'(IDLE));
        check("post_reset_valid", avg_valid, 0);

        // Warm-up again proves fill and sum were cleared.
        avg_ready = 1'b1;
        vs = valid_seen;
        send_sample(8'd4);
        send_sample(8'd8);
        send_sample(8'd12);
        check("rewarm_no_valid", valid_seen, vs);
        exp_q.push_back(8'd10);
        send_sample(8'd16);
        drain("rewarm_avg");

        repeat (5) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
